// File: rtl/pc_fetch_prefetch_unit.sv
// pc_fetch_prefetch_unit
//   Instruction-fetch front end: PC register, sequential next-PC adder,
//   redirect mux and a prefetch FIFO. Requests go out in order, responses are
//   paired with the PC recorded at request time and buffered for the decoder.
//
// Ports
//   clk             in   clock, rising edge
//   reset           in   asynchronous active-low reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts request
//   imem_addr       out  fetch address (current fetch_pc)
//   imem_rsp_valid  in   response valid, in request order
//   imem_rsp_data   in   fetched instruction
//   redirect_valid  in   one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc     in   redirect target
//   instr_valid     out  FIFO head valid
//   instr_ready     in   consumer accepts head
//   instr_data      out  head instruction
//   instr_pc        out  address of head instruction
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters
//   perf_fetched[31:0], perf_dropped[31:0], perf_redirects[15:0].
//
// FSM
//   state | meaning
//   IDLE  | first cycle after reset release, no requests
//   FETCH | issuing requests while FIFO + outstanding has room
//   DRAIN | discarding responses of requests made before a redirect

module pc_fetch_prefetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                INSTR_W    = 32,
    parameter int unsigned       PC_STEP    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped,
    output logic [15:0]        perf_redirects
`endif
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [CNT_W-1:0]   in_flight;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   fifo_count;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W-1:0]   pcq_wr, pcq_rd;

    logic [ADDR_W-1:0]  pcq_mem   [FIFO_DEPTH];
    logic [ADDR_W-1:0]  fifo_pc   [FIFO_DEPTH];
    logic [INSTR_W-1:0] fifo_data [FIFO_DEPTH];

    logic               req_fire, rsp_take, rsp_live, pcq_push, pop;
    logic [CNT_W-1:0]   drop_on_redirect;

    assign req_fire = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_take = imem_rsp_valid && (in_flight != '0);
    assign rsp_live = rsp_take && (drop_cnt == '0) && !redirect_valid;
    assign pcq_push = req_fire && !redirect_valid;
    assign pop      = instr_valid && instr_ready;

    // Everything outstanding after this edge becomes stale, including a
    // request that fires in the redirect cycle itself.
    assign drop_on_redirect = in_flight - CNT_W'(rsp_take) + CNT_W'(req_fire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (redirect_valid && (drop_on_redirect != '0)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (redirect_valid)
                    state_nxt = (drop_on_redirect != '0) ? DRAIN : FETCH;
                else if (rsp_take && (drop_cnt == CNT_W'(1)))
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reserving a FIFO slot per outstanding request means responses never
    // need backpressure.
    always_comb begin
        imem_req_valid = 1'b0;
        if (state == FETCH)
            imem_req_valid = ({1'b0, fifo_count} + {1'b0, in_flight}) < DEPTH_C;
    end

    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            in_flight <= in_flight + CNT_W'(req_fire) - CNT_W'(rsp_take);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                drop_cnt <= drop_on_redirect;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + STEP;
                if (rsp_take && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pcq_wr     <= '0;
            pcq_rd     <= '0;
            fifo_count <= '0;
        end else if (redirect_valid) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pcq_wr     <= '0;
            pcq_rd     <= '0;
            fifo_count <= '0;
        end else begin
            if (pcq_push) pcq_wr <= pcq_wr + PTR_W'(1);
            if (rsp_live) begin
                pcq_rd <= pcq_rd + PTR_W'(1);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(rsp_live) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (pcq_push)
            pcq_mem[pcq_wr] <= fetch_pc;
        if (rsp_live) begin
            fifo_pc[wr_ptr]   <= pcq_mem[pcq_rd];
            fifo_data[wr_ptr] <= imem_rsp_data;
        end
    end

    // Head is masked to zero while empty so flushed entries never show.
    assign instr_valid = (fifo_count != '0);
    assign instr_data  = instr_valid ? fifo_data[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;

`ifdef FETCH_PERF_CNT_EN
    logic rsp_dropped;
    assign rsp_dropped = rsp_take && (redirect_valid || (drop_cnt != '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched   <= '0;
            perf_dropped   <= '0;
            perf_redirects <= '0;
        end else begin
            if (pop && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if (rsp_dropped && (perf_dropped != '1))
                perf_dropped <= perf_dropped + 32'd1;
            if (redirect_valid && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_prefetch_unit.sv
// Testbench for pc_fetch_prefetch_unit: directed scenarios plus randomized
// traffic against a stream-level reference (expected request and delivery
// addresses, outstanding queue of the memory model).

module tb_pc_fetch_prefetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] STEP  = 32'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc;

    logic        w_req_valid, w_rsp_valid, w_instr_valid;
    logic [31:0] w_addr, w_rsp_data, w_instr_data, w_instr_pc;

    always #5 clk = ~clk;

    pc_fetch_prefetch_unit #(
        .ADDR_W(32), .INSTR_W(32), .PC_STEP(4), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
    );

    pc_fetch_prefetch_unit #(
        .ADDR_W(32), .INSTR_W(32), .PC_STEP(4), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)
    ) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_addr(w_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(w_instr_valid), .instr_ready(1'b1),
        .instr_data(w_instr_data), .instr_pc(w_instr_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One-cycle memory for the wrap instance.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_rsp_valid <= 1'b0;
            w_rsp_data  <= 32'h0;
        end else begin
            w_rsp_valid <= w_req_valid;
            w_rsp_data  <= mem_word(w_addr);
        end
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc, pops, fires, stale_left;
    bit          expect_req;
    logic [31:0] exp_req_pc, exp_pop_pc;
    int          p_req_rdy, p_cons, p_rsp, p_redir, lat_min, lat_max;

    logic        obs_req_valid, obs_instr_valid, obs_w_valid;
    logic [31:0] obs_instr_pc, obs_w_pc, obs_w_data;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the next negedge after one clock edge.
    task automatic step(input bit force_redir, input logic [31:0] force_pc);
        bit          fire, pop, rsp, redir;
        logic [31:0] addr_s, rpc;
        mreq_t       e;
        imem_req_ready = ($urandom_range(0, 99) < p_req_rdy);
        instr_ready    = ($urandom_range(0, 99) < p_cons);
        rsp = (mem_q.size() != 0) && ($urandom_range(0, 99) < p_rsp);
        if (rsp) rsp = (mem_q[0].due <= cyc + 1);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
        redir = force_redir || ($urandom_range(0, 999) < p_redir);
        rpc   = force_redir ? force_pc : ($urandom & 32'hFFFF_FFFC);
        redirect_valid = redir;
        redirect_pc    = redir ? rpc : $urandom;
        #1;
        obs_req_valid   = imem_req_valid;
        obs_instr_valid = instr_valid;
        obs_instr_pc    = instr_pc;
        obs_w_valid     = w_instr_valid;
        obs_w_pc        = w_instr_pc;
        obs_w_data      = w_instr_data;
        fire   = imem_req_valid && imem_req_ready;
        pop    = instr_valid && instr_ready;
        addr_s = imem_addr;
        if (stale_left > 0) chk_val("drain_no_req", {31'h0, imem_req_valid}, 32'h0);
        if (expect_req)     chk_val("restart_req", {31'h0, imem_req_valid}, 32'h1);
        if (fire) chk_val("req_addr", imem_addr, exp_req_pc);
        if (pop) begin
            chk_val("pop_pc", instr_pc, exp_pop_pc);
            chk_val("pop_data", instr_data, mem_word(exp_pop_pc));
        end
        @(posedge clk);
        cyc++;
        expect_req = 1'b0;
        if (rsp) begin
            void'(mem_q.pop_front());
            if (stale_left > 0) begin
                stale_left--;
                if (stale_left == 0) expect_req = 1'b1;
            end
        end
        if (fire) begin
            e.addr = addr_s;
            e.due  = cyc + $urandom_range(lat_min, lat_max);
            mem_q.push_back(e);
            chk_val("outstanding_le_depth", {31'h0, mem_q.size() <= DEPTH}, 32'h1);
            exp_req_pc += STEP;
            fires++;
        end
        if (pop) begin
            exp_pop_pc += STEP;
            pops++;
        end
        if (redir) begin
            exp_req_pc = rpc;
            exp_pop_pc = rpc;
            stale_left = mem_q.size();
            expect_req = (stale_left == 0);
        end
        @(negedge clk);
    endtask

    // Called at a negedge; asserts reset mid-cycle, checks the asynchronous
    // clear, and releases at a later negedge.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk_val("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk_val("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk_val("rst_imem_addr", imem_addr, 32'h0);
        chk_val("rst_instr_data", instr_data, 32'h0);
        chk_val("rst_instr_pc", instr_pc, 32'h0);
        chk_val("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_q.delete();
        exp_req_pc = 32'h0;
        exp_pop_pc = 32'h0;
        stale_left = 0;
        expect_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic set_knobs(input int rdy, input int cons, input int rspp, input int redir,
                             input int lmin, input int lmax);
        p_req_rdy = rdy;
        p_cons    = cons;
        p_rsp     = rspp;
        p_redir   = redir;
        lat_min   = lmin;
        lat_max   = lmax;
    endtask

    logic        v_hist [1:7];
    logic        rv_hist[1:7];
    logic [31:0] pc_hist[1:7];
    logic        wv_hist[1:7];
    logic [31:0] wpc_hist[1:7];
    logic [31:0] wd_hist[1:7];
    logic [31:0] wrap_exp[0:2];
    int          pops_before;

    initial begin
        cyc = 0; pops = 0; fires = 0; stale_left = 0; expect_req = 1'b0;
        set_knobs(100, 100, 100, 0, 1, 1);
        @(negedge clk);

        // Reset values, first-word latency, back-to-back delivery, PC wrap.
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 32'h0);
            v_hist[k]   = obs_instr_valid;
            rv_hist[k]  = obs_req_valid;
            pc_hist[k]  = obs_instr_pc;
            wv_hist[k]  = obs_w_valid;
            wpc_hist[k] = obs_w_pc;
            wd_hist[k]  = obs_w_data;
        end
        chk_val("idle_no_req", {31'h0, rv_hist[1]}, 32'h0);
        chk_val("fetch_req", {31'h0, rv_hist[2]}, 32'h1);
        for (int k = 1; k <= 3; k++) chk_val("first_word_early", {31'h0, v_hist[k]}, 32'h0);
        for (int k = 4; k <= 7; k++) begin
            chk_val("stream_valid", {31'h0, v_hist[k]}, 32'h1);
            chk_val("stream_pc", pc_hist[k], 32'(k - 4) * STEP);
        end
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        for (int k = 4; k <= 6; k++) begin
            chk_val("wrap_valid", {31'h0, wv_hist[k]}, 32'h1);
            chk_val("wrap_pc", wpc_hist[k], wrap_exp[k - 4]);
            chk_val("wrap_data", wd_hist[k], mem_word(wrap_exp[k - 4]));
        end

        // Consumer stalled: exactly DEPTH requests, then none until a pop.
        do_reset();
        set_knobs(100, 0, 100, 0, 1, 1);
        fires = 0;
        for (int k = 0; k < 10; k++) step(1'b0, 32'h0);
        chk_val("stall_fires", 32'(fires), 32'(DEPTH));
        chk_val("stall_no_req", {31'h0, obs_req_valid}, 32'h0);
        p_cons = 100;
        step(1'b0, 32'h0);
        p_cons = 0;
        step(1'b0, 32'h0);
        chk_val("req_after_pop", {31'h0, obs_req_valid}, 32'h1);

        // Redirect with rsp and req in the same cycle (3 in flight),
        // then the same followed by a second redirect while draining.
        for (int v = 0; v < 2; v++) begin
            do_reset();
            set_knobs(100, 0, 100, 0, 3, 3);
            for (int k = 0; k < 4; k++) step(1'b0, 32'h0);
            step(1'b1, 32'h0000_0100);
            if (v == 1) step(1'b1, 32'h0000_0200);
            p_cons = 100;
            pops_before = pops;
            for (int k = 0; k < 20; k++) step(1'b0, 32'h0);
            chk_val("post_redirect_progress", {31'h0, (pops - pops_before) >= 8}, 32'h1);
        end

        // Randomized traffic with a mid-stream reset.
        do_reset();
        pops_before = pops;
        for (int blk = 0; blk < 20; blk++) begin
            set_knobs($urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(40, 100),
                      $urandom_range(0, 60), 1, $urandom_range(1, 4));
            if (blk == 10) do_reset();
            for (int k = 0; k < 200; k++) step(1'b0, 32'h0);
        end
        chk_val("random_progress", {31'h0, (pops - pops_before) > 200}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
